// File: rtl/apb_fifo_slave.sv
// APB completer exposing a word FIFO mailbox, status/control and scratch registers.
// Optional interrupt enable and irq output are compiled in with APB_FIFO_SLAVE_IRQ_EN.
module apb_fifo_slave #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CntFull  = CW'(DEPTH);
    localparam logic [2:0]    WaitLast = 3'(WAIT_CYCLES);

    localparam logic [9:0] AddrFdr = 10'h000;
    localparam logic [9:0] AddrFsr = 10'h001;
    localparam logic [9:0] AddrFcr = 10'h002;
    localparam logic [9:0] AddrScr = 10'h003;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic [31:0]   scr_q, scr_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic          ien;

    logic [9:0]  reg_addr;
    logic        access, empty, full;
    logic        wr_fdr, rd_fdr, wr_fcr, wr_scr, clr, push, pop;
    logic [31:0] rdata;
    logic        unused_paddr;

    assign unused_paddr = ^{PADDR[31:12], PADDR[1:0]};

    assign reg_addr = PADDR[11:2];
    assign access   = PSEL & PENABLE;
    // Gated by reset so a transfer caught mid-ACCESS by reset never completes.
    assign PREADY   = PRESETn & access & (wcnt_q == WaitLast);

    assign empty  = (count_q == '0);
    assign full   = (count_q == CntFull);
    assign wr_fdr = PREADY & PWRITE & (reg_addr == AddrFdr);
    assign rd_fdr = PREADY & ~PWRITE & (reg_addr == AddrFdr);
    assign wr_fcr = PREADY & PWRITE & (reg_addr == AddrFcr);
    assign wr_scr = PREADY & PWRITE & (reg_addr == AddrScr);
    assign clr    = wr_fcr & PWDATA[0];
    assign push   = wr_fdr & ~full;
    assign pop    = rd_fdr & ~empty;

    always_comb begin
        wcnt_d   = (access && !PREADY) ? wcnt_q + 3'd1 : 3'd0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        scr_d    = wr_scr ? PWDATA : scr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
            end
            if (wr_fdr && full) ovf_d = 1'b1;
            if (rd_fdr && empty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            scr_q    <= '0;
            wcnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            scr_q    <= scr_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Storage is not reset; CLR only rewinds the pointers.
    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q] <= PWDATA;
    end

    always_comb begin
        rdata = '0;
        case (reg_addr)
            AddrFdr: rdata = empty ? 32'd0 : mem_q[rd_ptr_q];
            AddrFsr: begin
                rdata[0]       = empty;
                rdata[1]       = full;
                rdata[2]       = ovf_q;
                rdata[3]       = udf_q;
                rdata[4]       = ien;
                rdata[16 +: CW] = count_q;
            end
            AddrScr: rdata = scr_q;
            default: rdata = '0;
        endcase
        PRDATA = (PRESETn && PSEL && !PWRITE) ? rdata : 32'd0;
    end

`ifdef APB_FIFO_SLAVE_IRQ_EN
    logic ien_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ien_q <= 1'b0;
        end else if (wr_fcr) begin
            ien_q <= PWDATA[1];
        end
    end

    assign ien = ien_q;
    assign irq = ien_q & (~empty | ovf_q);
`else
    assign ien = 1'b0;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Self-checking bench for apb_fifo_slave: vector table plus queue scoreboard of FIFO contents.
module tb_apb_fifo_slave;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned WAIT_CYC = 3;

    localparam logic [11:0] A_FDR = 12'h000;
    localparam logic [11:0] A_FSR = 12'h004;
    localparam logic [11:0] A_FCR = 12'h008;
    localparam logic [11:0] A_SCR = 12'h00C;
    localparam logic [11:0] A_UNM = 12'h010;

`ifdef APB_FIFO_SLAVE_IRQ_EN
    localparam logic IrqOn = 1'b1;
`else
    localparam logic IrqOn = 1'b0;
`endif

    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PENABLE, PSEL, PREADY, irq;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb_q[$];
    logic        m_ovf, m_udf, m_ien;
    logic [31:0] m_scr;
    vec_t        vecs[13];
    logic [31:0] rd;

    always #5 PCLK = ~PCLK;

    apb_fifo_slave #(
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAIT_CYC)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PWRITE (PWRITE),
        .PENABLE(PENABLE),
        .PSEL   (PSEL),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .irq    (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_fsr();
        int c;
        c = sb_q.size();
        return {7'd0, 9'(c), 11'd0, m_ien, m_udf, m_ovf, (c == DEPTH), (c == 0)};
    endfunction

    function automatic logic model_irq();
`ifdef APB_FIFO_SLAVE_IRQ_EN
        return m_ien & ((sb_q.size() != 0) | m_ovf);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        sb_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_ien = 1'b0;
        m_scr = 32'd0;
    endfunction

    // One APB transfer; entered and left 1 time unit after a rising edge.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdo);
        int          lat;
        logic [31:0] exp_rd;
        lat    = 0;
        exp_rd = 32'd0;
        if (!wr) begin
            case (addr)
                A_FDR:   if (sb_q.size() != 0) exp_rd = sb_q[0];
                A_FSR:   exp_rd = model_fsr();
                A_SCR:   exp_rd = m_scr;
                default: exp_rd = 32'd0;
            endcase
        end
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = {20'h10002, addr};
        PWDATA  = wd;
        #1 check("setup_pready", {31'd0, PREADY}, 32'd0);
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        #1;
        while (!PREADY && lat < 20) begin
            @(posedge PCLK);
            #2;
            lat++;
        end
        check("latency", 32'(lat), 32'(WAIT_CYC));
        rdo = PRDATA;
        if (!wr) check("sb_rdata", rdo, exp_rd);
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        if (wr) begin
            case (addr)
                A_FDR: begin
                    if (sb_q.size() < DEPTH) sb_q.push_back(wd);
                    else m_ovf = 1'b1;
                end
                A_FCR: begin
                    if (wd[0]) begin
                        sb_q.delete();
                        m_ovf = 1'b0;
                        m_udf = 1'b0;
                    end
`ifdef APB_FIFO_SLAVE_IRQ_EN
                    m_ien = wd[1];
`endif
                end
                A_SCR:   m_scr = wd;
                default: ;
            endcase
        end else if (addr == A_FDR) begin
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            else m_udf = 1'b1;
        end
        check("irq", {31'd0, irq}, {31'd0, model_irq()});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'd0;
        PWDATA  = 32'd0;
        model_reset();
        vecs = '{
            '{1'b1, A_FDR, 32'hA5A5_0001, 32'h0},
            '{1'b1, A_FDR, 32'hA5A5_0002, 32'h0},
            '{1'b0, A_FSR, 32'h0, 32'h0002_0000},
            '{1'b0, A_FDR, 32'h0, 32'hA5A5_0001},
            '{1'b0, A_FDR, 32'h0, 32'hA5A5_0002},
            '{1'b0, A_FSR, 32'h0, 32'h0000_0001},
            '{1'b1, A_SCR, 32'hDEAD_BEEF, 32'h0},
            '{1'b0, A_SCR, 32'h0, 32'hDEAD_BEEF},
            '{1'b0, A_UNM, 32'h0, 32'h0},
            '{1'b1, A_UNM, 32'hFFFF_FFFF, 32'h0},
            '{1'b0, A_FCR, 32'h0, 32'h0},
            '{1'b0, A_SCR, 32'h0, 32'hDEAD_BEEF},
            '{1'b0, A_FSR, 32'h0, 32'h0000_0001}
        };

        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        PRESETn = 1'b1;

        // Reset during an FSR read that is already showing PREADY.
        xfer(1'b1, A_SCR, 32'h1234_5678, rd);
        xfer(1'b1, A_FDR, 32'h0BAD_F00D, rd);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = {20'h10002, A_FSR};
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        repeat (WAIT_CYC) @(posedge PCLK);
        #1;
        check("pre_rst_pready", {31'd0, PREADY}, 32'd1);
        check("pre_rst_prdata", PRDATA, 32'h0001_0000);
        PRESETn = 1'b0;
        #1;
        check("mid_rst_pready", {31'd0, PREADY}, 32'd0);
        check("mid_rst_prdata", PRDATA, 32'd0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        model_reset();
        xfer(1'b0, A_FSR, 32'd0, rd);
        check("post_rst_fsr", rd, 32'h0000_0001);
        xfer(1'b0, A_SCR, 32'd0, rd);
        check("post_rst_scr", rd, 32'd0);

        foreach (vecs[i]) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, rd);
            if (!vecs[i].wr) check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // Overflow, drain past empty, then CLR.
        for (int i = 0; i <= DEPTH; i++) xfer(1'b1, A_FDR, 32'hC0DE_0000 + 32'(i), rd);
        xfer(1'b0, A_FSR, 32'd0, rd);
        check("full_fsr", rd, 32'h0010_0006);
        for (int i = 0; i <= DEPTH; i++) xfer(1'b0, A_FDR, 32'd0, rd);
        check("underflow_data", rd, 32'd0);
        xfer(1'b0, A_FSR, 32'd0, rd);
        check("udf_fsr", rd, 32'h0000_000D);
        xfer(1'b1, A_FCR, 32'h1, rd);
        xfer(1'b0, A_FSR, 32'd0, rd);
        check("clr_fsr", rd, 32'h0000_0001);

        // Pointer wrap with interleaved pairs; scoreboard checks order and count.
        for (int i = 0; i < 20; i++) begin
            xfer(1'b1, A_FDR, 32'h5A00_0000 + 32'(2 * i), rd);
            xfer(1'b1, A_FDR, 32'h5A00_0000 + 32'(2 * i + 1), rd);
            xfer(1'b0, A_FSR, 32'd0, rd);
            xfer(1'b0, A_FDR, 32'd0, rd);
            xfer(1'b0, A_FDR, 32'd0, rd);
        end

        // Interrupt behaviour (tied low without the macro).
        xfer(1'b1, A_FCR, 32'h2, rd);
        check("irq_ien_empty", {31'd0, irq}, 32'd0);
        xfer(1'b1, A_FDR, 32'h7777_0001, rd);
        check("irq_push", {31'd0, irq}, {31'd0, IrqOn});
        xfer(1'b0, A_FSR, 32'd0, rd);
        check("ien_fsr", rd, {27'h0000800, IrqOn, 4'h0});
        xfer(1'b0, A_FDR, 32'd0, rd);
        check("irq_pop", {31'd0, irq}, 32'd0);
        for (int i = 0; i <= DEPTH; i++) xfer(1'b1, A_FDR, 32'h9000_0000 + 32'(i), rd);
        for (int i = 0; i < DEPTH; i++) xfer(1'b0, A_FDR, 32'd0, rd);
        check("irq_ovf_sticky", {31'd0, irq}, {31'd0, IrqOn});
        xfer(1'b1, A_FCR, 32'h3, rd);
        check("irq_clr", {31'd0, irq}, 32'd0);
        xfer(1'b0, A_FSR, 32'd0, rd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
